// File: rtl/bus_responder.sv
// Memory-side responder for the CPU word bus: word RAM plus an I/O page with GPIO,
// a free-running cycle counter and a compare timer driving a level interrupt.
module bus_responder #(
  parameter int                   BITS_DATA = 32,
  parameter int                   BITS_ADDR = 16,
  parameter int                   MEM_AW    = 12,
  parameter logic [BITS_ADDR-1:0] IO_BASE   = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BITS_ADDR-1:0] MAR,
  input  logic [BITS_DATA-1:0] MBR_W,
  input  logic                 write,
  output logic [BITS_DATA-1:0] MBR_R,
  input  logic [7:0]           gpio_in,
  output logic [7:0]           gpio_out,
  output logic                 irq
);

  localparam logic [BITS_ADDR:0] RAM_END = (BITS_ADDR+1)'(1) << MEM_AW;
  localparam logic [BITS_ADDR:0] IO_END  = {1'b0, IO_BASE} + (BITS_ADDR+1)'(8);

  logic [BITS_DATA-1:0] ram [2**MEM_AW];

  logic                 armed_q;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          cmp_q, cmp_d;
  logic                 status_q, status_d;
  logic                 irq_en_q, irq_en_d;
  logic [7:0]           gpio_out_q, gpio_out_d;
  logic [7:0]           gpio_s1_q, gpio_s2_q;
  logic [BITS_DATA-1:0] rd_d, rd_q;
  logic                 ram_hit, io_hit, we, ram_we, io_we, match;

  // The I/O page is decoded on MAR[2:0], so IO_BASE must be 8-word aligned.
  assign ram_hit = {1'b0, MAR} < RAM_END;
  assign io_hit  = (MAR >= IO_BASE) && ({1'b0, MAR} < IO_END);
  // armed_q drops the write pending at the first edge after reset.
  assign we      = write && armed_q;
  assign ram_we  = we && ram_hit;
  assign io_we   = we && io_hit;
  assign match   = (cnt_q == cmp_q);

  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    cmp_d      = cmp_q;
    status_d   = status_q;
    irq_en_d   = irq_en_q;
    gpio_out_d = gpio_out_q;
    if (io_we) begin
      case (MAR[2:0])
        3'd0:    gpio_out_d = MBR_W[7:0];
        3'd2:    cmp_d = MBR_W[31:0];
        3'd3:    if (MBR_W[0]) status_d = 1'b0;
        3'd4:    irq_en_d = MBR_W[0];
        default: ;
      endcase
    end
    // A match on the same edge as a clearing write keeps the flag set.
    if (match) status_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      status_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
    end else begin
      armed_q    <= 1'b1;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      status_q   <= status_d;
      irq_en_q   <= irq_en_d;
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_in;
      gpio_s2_q  <= gpio_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[MAR[MEM_AW-1:0]] <= MBR_W;
  end

  always_comb begin
    rd_d = '0;
    if (ram_hit) begin
      rd_d = ram[MAR[MEM_AW-1:0]];
    end else if (io_hit) begin
      case (MAR[2:0])
        3'd0:    rd_d = BITS_DATA'(gpio_out_q);
        3'd1:    rd_d = BITS_DATA'(cnt_q);
        3'd2:    rd_d = BITS_DATA'(cmp_q);
        3'd3:    rd_d = BITS_DATA'(status_q);
        3'd4:    rd_d = BITS_DATA'(irq_en_q);
        3'd5:    rd_d = BITS_DATA'(gpio_s2_q);
        default: rd_d = '0;
      endcase
    end
  end

  // Read data is captured mid-cycle so the CPU samples it on the next rising edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign MBR_R    = rd_q;
  assign gpio_out = gpio_out_q;
  assign irq      = status_q & irq_en_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: RAM, unmapped space, GPIO, cycle counter, compare timer,
// counter wrap and reset during a pending write.
module tb_bus_responder;

  localparam logic [15:0] IO = 16'hFF00;

  logic        clk;
  logic        reset_n;
  logic [15:0] MAR;
  logic [31:0] MBR_W;
  logic        write;
  logic [31:0] MBR_R;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] ram_m [logic [15:0]];
  logic [31:0] cyc_m;

  bus_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .MAR      (MAR),
    .MBR_W    (MBR_W),
    .write    (write),
    .MBR_R    (MBR_R),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference cycle counter
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_m <= '0;
    else          cyc_m <= cyc_m + 32'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // drivers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    MAR   = a;
    MBR_W = d;
    write = 1'b1;
    cycle();
    write = 1'b0;
  endtask

  task automatic sb_read(input logic [15:0] a, input logic [31:0] expv,
                         output logic [31:0] got, output logic [31:0] e);
    exp_q.push_back(expv);
    MAR   = a;
    write = 1'b0;
    @(negedge clk);
    #1;
    got = MBR_R;
    e   = exp_q.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    reset_n = 1'b0;
    MAR     = '0;
    MBR_W   = '0;
    write   = 1'b0;
    gpio_in = '0;
    repeat (3) cycle();
    checks++; if (MBR_R !== 32'h0) begin errors++; $display("FAIL rst_mbr_r got %h exp 0", MBR_R); end
    checks++; if (gpio_out !== 8'h0) begin errors++; $display("FAIL rst_gpio_out got %h exp 0", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    reset_n = 1'b1;
    cycle();
    sb_read(IO + 16'd2, 32'hFFFF_FFFF, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL rst_compare got %h exp %h", got, e); end
    sb_read(IO + 16'd3, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL rst_status got %h exp %h", got, e); end
    sb_read(IO + 16'd4, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL rst_ctrl got %h exp %h", got, e); end
  endtask

  task automatic test_ram();
    logic [31:0] got, e, d;
    logic [15:0] a;
    bus_write(16'h0010, 32'hDEAD_BEEF);
    ram_m[16'h0010] = 32'hDEAD_BEEF;
    sb_read(16'h0010, 32'hDEAD_BEEF, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL ram_0010 got %h exp %h", got, e); end
    sb_read(16'h2000, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL unmapped_rd got %h exp %h", got, e); end
    bus_write(16'h2000, 32'h1234_5678);
    sb_read(16'h2000, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL unmapped_wr got %h exp %h", got, e); end
    bus_write(16'h0000, 32'hA0A0_A0A0);
    ram_m[16'h0000] = 32'hA0A0_A0A0;
    bus_write(16'h0FFF, 32'hCAFE_F00D);
    ram_m[16'h0FFF] = 32'hCAFE_F00D;
    bus_write(16'h1000, 32'h1111_1111);
    sb_read(16'h1000, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL ram_end_rd got %h exp %h", got, e); end
    sb_read(16'h0000, 32'hA0A0_A0A0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL ram_alias got %h exp %h", got, e); end
    sb_read(16'h0FFF, 32'hCAFE_F00D, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL ram_top got %h exp %h", got, e); end
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(32, 4094));
      d = $urandom;
      bus_write(a, d);
      ram_m[a] = d;
    end
    foreach (ram_m[k]) begin
      sb_read(k, ram_m[k], got, e);
      checks++; if (got !== e) begin errors++; $display("FAIL ram_rand[%h] got %h exp %h", k, got, e); end
    end
    bus_write(IO + 16'd6, 32'hFFFF_FFFF);
    sb_read(IO + 16'd6, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL io_reserved got %h exp %h", got, e); end
    sb_read(16'hFFFF, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL addr_ffff got %h exp %h", got, e); end
  endtask

  task automatic test_gpio();
    logic [31:0] got, e;
    logic [7:0]  v;
    bus_write(IO, 32'h1234_56A5);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out got %h exp a5", gpio_out); end
    sb_read(IO, 32'h0000_00A5, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL gpio_out_rd got %h exp %h", got, e); end
    gpio_in = 8'h3C;
    cycle();
    cycle();
    sb_read(IO + 16'd5, 32'h0000_003C, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL gpio_in got %h exp %h", got, e); end
    bus_write(IO + 16'd5, 32'hFFFF_FFFF);
    sb_read(IO + 16'd5, 32'h0000_003C, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL gpio_in_ro got %h exp %h", got, e); end
    v = 8'($urandom_range(0, 255));
    gpio_in = v;
    cycle();
    cycle();
    sb_read(IO + 16'd5, {24'h0, v}, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL gpio_in_rand got %h exp %h", got, e); end
  endtask

  task automatic test_timer();
    logic [31:0] got, e, target;
    int          guard;
    bus_write(IO + 16'd4, 32'h1);
    sb_read(IO + 16'd4, 32'h1, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL ctrl_rd got %h exp %h", got, e); end
    sb_read(IO + 16'd1, cyc_m, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL cycles_rd got %h exp %h", got, e); end
    bus_write(IO + 16'd1, 32'h0);
    sb_read(IO + 16'd1, cyc_m, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL cycles_ro got %h exp %h", got, e); end
    target = cyc_m + 32'd20;
    bus_write(IO + 16'd2, target);
    for (int i = 0; i < 26; i++) begin
      cycle();
      checks++;
      if (irq !== (cyc_m > target)) begin
        errors++; $display("FAIL timer_irq[cyc %h] got %b exp %b", cyc_m, irq, cyc_m > target);
      end
    end
    bus_write(IO + 16'd3, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
    sb_read(IO + 16'd3, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL w1c_status got %h exp %h", got, e); end
    target = cyc_m + 32'd6;
    bus_write(IO + 16'd2, target);
    guard = 0;
    while (cyc_m != target && guard < 20) begin
      cycle();
      guard++;
    end
    checks++; if (cyc_m !== target) begin errors++; $display("FAIL w1c_sync got %h exp %h", cyc_m, target); end
    bus_write(IO + 16'd3, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", irq); end
    sb_read(IO + 16'd3, 32'h1, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL set_wins_status got %h exp %h", got, e); end
    bus_write(IO + 16'd3, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c2_irq got %b exp 0", irq); end
    target = cyc_m;
    bus_write(IO + 16'd2, target);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cmp_eq_now[%0d] got %b exp 0", i, irq); end
    end
    sb_read(IO + 16'd2, target, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL compare_rd got %h exp %h", got, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, prev_val;
    logic        prev_irq, irq_after;
    bit          found;
    bus_write(IO + 16'd2, 32'h0);
    bus_write(IO + 16'd3, 32'h1);
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFA;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    prev_val = 32'h0;
    prev_irq = 1'b1;
    found    = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      MAR   = IO + 16'd1;
      write = 1'b0;
      @(negedge clk);
      #1;
      got = MBR_R;
      @(posedge clk);
      #1;
      irq_after = irq;
      if (got == 32'h0) begin
        found = 1'b1;
        checks++; if (prev_val !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_prev got %h exp ffffffff", prev_val); end
        checks++; if (prev_irq !== 1'b0) begin errors++; $display("FAIL wrap_early_irq got %b exp 0", prev_irq); end
        checks++; if (irq_after !== 1'b1) begin errors++; $display("FAIL wrap_match_irq got %b exp 1", irq_after); end
      end
      prev_val = got;
      prev_irq = irq_after;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wrap_timeout got %h exp 00000000", prev_val);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, e;
    MAR   = IO;
    MBR_W = 32'h0000_0077;
    write = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (gpio_out !== 8'h0) begin errors++; $display("FAIL mid_rst_gpio got %h exp 0", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", irq); end
    checks++; if (MBR_R !== 32'h0) begin errors++; $display("FAIL mid_rst_mbr_r got %h exp 0", MBR_R); end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    checks++; if (gpio_out !== 8'h0) begin errors++; $display("FAIL mid_rst_drop got %h exp 0", gpio_out); end
    cycle();
    sb_read(IO, 32'h0, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL mid_rst_gpio_rd got %h exp %h", got, e); end
    sb_read(IO + 16'd2, 32'hFFFF_FFFF, got, e);
    checks++; if (got !== e) begin errors++; $display("FAIL mid_rst_compare got %h exp %h", got, e); end
    foreach (ram_m[k]) begin
      sb_read(k, ram_m[k], got, e);
      checks++; if (got !== e) begin errors++; $display("FAIL mid_rst_ram[%h] got %h exp %h", k, got, e); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
